riscv_pipeline_ctrl: RTL
========================

RISCV_PIPELINE_CTRL -- requirements
Module: riscv_pipeline_ctrl

Interface
REQ-001 SHALL have parameter MDIV_TIMEOUT, default 64, max EX cycles a mul/div may stay busy before error.
REQ-002 SHALL have ports: i_clk input 1 clock; i_rstn input 1 reset, asynchronous, active-low.
REQ-003 SHALL have inputs: i_id_rs1/i_id_rs2 (5 each) ID source regs; i_id_rs1_used/i_id_rs2_used (1 each) source valid.
REQ-004 SHALL have inputs: i_ex_rd (5) EX dest reg; i_ex_is_load (1) EX instr is load; i_ex_redirect (1) EX branch/jump taken.
REQ-005 SHALL have inputs: i_ex_mdiv_start (1) EX issues mul/div; i_mdiv_done (1) mul/div result ready.
REQ-006 SHALL have inputs: i_imem_ready (1) fetch data valid; i_mem_req (1) MEM access active; i_mem_ready (1) data memory ack.
REQ-007 SHALL have outputs (1 each, 1=keep value): o_hold_pc, o_hold_ifid, o_hold_idex, o_hold_exmem.
REQ-008 SHALL have outputs (1 each, 1=clear to bubble next edge): o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb.
REQ-009 SHALL have outputs: o_stall_cnt (`XLEN) stall-cycle count; o_mdiv_err (1) sticky timeout flag; o_state (2) FSM state.

Function
REQ-010 SHALL implement FSM states S_RUN=0, S_MDIV=1, S_DWAIT=2; S_DWAIT entry/exit evaluated each cycle from i_mem_req && !i_mem_ready.
REQ-011 SHALL define dwait = i_mem_req && !i_mem_ready; while dwait: hold pc/ifid/idex/exmem, flush memwb, all other flushes 0.
REQ-012 SHALL give dwait highest priority; redirect, load-use, imem and mul/div actions suppressed that cycle, FSM stays/enters S_DWAIT.
REQ-013 SHALL, on leaving dwait, return to the state held before entry (S_RUN or S_MDIV); mdiv timeout counter frozen during dwait.
REQ-014 SHALL define load_use = i_ex_is_load && i_ex_rd!=0 && ((i_id_rs1_used && i_id_rs1==i_ex_rd) || (i_id_rs2_used && i_id_rs2==i_ex_rd)).
REQ-015 SHALL, on load_use in S_RUN without redirect: hold pc and ifid, flush idex, exactly one bubble per load.
REQ-016 SHALL, on i_ex_redirect in S_RUN: flush ifid and idex, no holds; redirect overrides load_use and imem stall.
REQ-017 SHALL, on !i_imem_ready in S_RUN (no redirect, no load_use): hold pc, flush ifid.
REQ-018 SHALL, on i_ex_mdiv_start in S_RUN: enter S_MDIV next cycle; the start cycle itself holds pc/ifid/idex and flushes exmem.
REQ-019 SHALL, in S_MDIV: hold pc/ifid/idex, flush exmem; on i_mdiv_done release all holds that cycle and return to S_RUN.
REQ-020 SHALL count S_MDIV cycles from 1; on reaching MDIV_TIMEOUT set o_mdiv_err (sticky until reset) and force S_RUN.
REQ-021 SHALL ignore i_ex_redirect while in S_MDIV (EX held); honour it on the cycle after return to S_RUN.
REQ-022 SHALL increment o_stall_cnt by 1 on every cycle with o_hold_pc=1, saturating at all-ones.
REQ-023 SHALL generate all hold/flush outputs combinationally from inputs and registered state, zero-cycle latency.

Reset
REQ-024 SHALL, on i_rstn low, asynchronously force S_RUN, timeout counter 0, o_stall_cnt 0, o_mdiv_err 0, saved state S_RUN.
REQ-025 SHALL, during reset, drive all hold outputs 0 and all flush outputs 1.
REQ-026 SHALL, on reset mid-S_MDIV or mid-dwait, abandon the operation; first post-reset cycle is S_RUN.

Structure
REQ-027 SHALL take `XLEN from riscv_configs.v; state encodings and the register-index width 5 SHALL live in that shared config file.
REQ-028 SHALL be a single module plus one sub-module riscv_hazard_detect (combinational load_use compare).

Verification
REQ-029 SHALL cover: EX lw x5, ID add x6,x5,x1 -> one cycle hold_pc=hold_ifid=1, flush_idex=1, then clean; rd=x0 -> no stall.
REQ-030 SHALL cover: load_use and i_ex_redirect same cycle -> flush_ifid=flush_idex=1, hold_pc=0, stall_cnt unchanged.
REQ-031 SHALL cover: mdiv_start, done after 5 cycles -> holds asserted 6 cycles total, o_state 1 then 0, stall_cnt +6.
REQ-032 SHALL cover: MDIV_TIMEOUT=8, done never -> o_mdiv_err=1 after cycle 8, S_RUN, flag stays 1 until reset.
REQ-033 SHALL cover: mem_ready low 3 cycles during S_MDIV -> flush_memwb=1 for 3 cycles, resumes S_MDIV, timeout count frozen.
REQ-034 SHALL cover: i_rstn low mid-S_MDIV -> o_state=0, stall_cnt=0, flushes=1 immediately, no holds after release.

Source files
------------

// File: rtl/riscv_pipeline_ctrl_pkg.sv
// Shared pipeline-control configuration: datapath width, register index width, FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pipeline_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MDIV  = 2'd1,
        S_DWAIT = 2'd2
    } ctrl_state_e;

    // Per-stage hold vector: 1 = pipeline register keeps its value.
    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
    } hold_t;

    // Per-stage flush vector: 1 = pipeline register becomes a bubble on the next edge.
    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } flush_t;

endpackage

// File: rtl/riscv_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the pipeline controller.
module riscv_hazard_detect
    import riscv_pipeline_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_rs1_used_i,
    input  logic                 id_rs2_used_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_is_load_i,
    output logic                 load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
        rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
        load_use_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/riscv_pipeline_ctrl.sv
// Pipeline hold/flush controller: data-memory wait, load-use, redirect, fetch stall, mul/div busy.
// Latency: hold/flush outputs are combinational (zero cycles); state, stall count and error are registered.
// Backpressure: data-memory wait stalls everything up to EX/MEM; mul/div stalls up to ID/EX until done or timeout.
module riscv_pipeline_ctrl
    import riscv_pipeline_ctrl_pkg::*;
#(
    parameter int MDIV_TIMEOUT = 64
)
(
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_rs1_used,
    input  logic                 i_id_rs2_used,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_is_load,
    input  logic                 i_ex_redirect,
    input  logic                 i_ex_mdiv_start,
    input  logic                 i_mdiv_done,
    input  logic                 i_imem_ready,
    input  logic                 i_mem_req,
    input  logic                 i_mem_ready,
    output logic                 o_hold_pc,
    output logic                 o_hold_ifid,
    output logic                 o_hold_idex,
    output logic                 o_hold_exmem,
    output logic                 o_flush_ifid,
    output logic                 o_flush_idex,
    output logic                 o_flush_exmem,
    output logic                 o_flush_memwb,
    output logic [XLEN-1:0]      o_stall_cnt,
    output logic                 o_mdiv_err,
    output logic [1:0]           o_state
);

    localparam int                TMO_W     = $clog2(MDIV_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MDIV_TIMEOUT);
    localparam logic [XLEN-1:0]   STALL_MAX = '1;

    ctrl_state_e      state_q;
    ctrl_state_e      saved_q;
    ctrl_state_e      eff_state;
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    logic [XLEN-1:0]  stall_q;
    logic [XLEN-1:0]  stall_d;

    logic             dwait;
    logic             load_use;
    logic             tmo_hit;
    hold_t            hold;
    flush_t           flush;

    riscv_hazard_detect u_hazard (
        .id_rs1_i      (i_id_rs1),
        .id_rs2_i      (i_id_rs2),
        .id_rs1_used_i (i_id_rs1_used),
        .id_rs2_used_i (i_id_rs2_used),
        .ex_rd_i       (i_ex_rd),
        .ex_is_load_i  (i_ex_is_load),
        .load_use_o    (load_use)
    );

    // The cycle that ends a data wait behaves as the state that was interrupted;
    // the mul/div cycle being evaluated is number tmo_q+1.
    always_comb begin
        dwait     = i_mem_req && !i_mem_ready;
        eff_state = (state_q == S_DWAIT) ? saved_q : state_q;
        tmo_hit   = (tmo_q + TMO_W'(1)) >= TMO_LAST;
    end

    // Hold/flush decode, highest priority first: reset, data wait, mul/div busy, redirect,
    // mul/div start, load-use, fetch not ready.
    always_comb begin
        hold  = '0;
        flush = '0;
        if (!i_rstn) begin
            flush = '1;
        end else if (dwait) begin
            hold        = '1;
            flush.memwb = 1'b1;
        end else if (eff_state == S_MDIV) begin
            // Result arrives on the done cycle, so EX proceeds and nothing is held.
            if (!i_mdiv_done) begin
                hold.pc     = 1'b1;
                hold.ifid   = 1'b1;
                hold.idex   = 1'b1;
                flush.exmem = 1'b1;
            end
        end else if (i_ex_redirect) begin
            flush.ifid = 1'b1;
            flush.idex = 1'b1;
        end else if (i_ex_mdiv_start) begin
            hold.pc     = 1'b1;
            hold.ifid   = 1'b1;
            hold.idex   = 1'b1;
            flush.exmem = 1'b1;
        end else if (load_use) begin
            hold.pc    = 1'b1;
            hold.ifid  = 1'b1;
            flush.idex = 1'b1;
        end else if (!i_imem_ready) begin
            hold.pc    = 1'b1;
            flush.ifid = 1'b1;
        end
    end

    // Controller FSM: data wait parks the interrupted state, mul/div counts busy cycles to a timeout.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_RUN;
            saved_q <= S_RUN;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else if (dwait) begin
            state_q <= S_DWAIT;
            if (state_q != S_DWAIT) begin
                saved_q <= state_q;
            end
        end else begin
            case (eff_state)
                S_MDIV: begin
                    if (i_mdiv_done) begin
                        state_q <= S_RUN;
                        tmo_q   <= '0;
                    end else if (tmo_hit) begin
                        state_q <= S_RUN;
                        tmo_q   <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= S_MDIV;
                        tmo_q   <= tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    if (!i_ex_redirect && i_ex_mdiv_start) begin
                        state_q <= S_MDIV;
                    end else begin
                        state_q <= S_RUN;
                    end
                    tmo_q <= '0;
                end
            endcase
        end
    end

    // Stall counter advances whenever the PC is held and sticks at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (hold.pc && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + XLEN'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_hold_pc     = hold.pc;
    assign o_hold_ifid   = hold.ifid;
    assign o_hold_idex   = hold.idex;
    assign o_hold_exmem  = hold.exmem;
    assign o_flush_ifid  = flush.ifid;
    assign o_flush_idex  = flush.idex;
    assign o_flush_exmem = flush.exmem;
    assign o_flush_memwb = flush.memwb;
    assign o_stall_cnt   = stall_q;
    assign o_mdiv_err    = err_q;
    assign o_state       = state_q;

endmodule
